id_branch_resolve_predict: RTL and testbench
============================================

Name: id_branch_resolve_predict

Overview:
ID-stage branch resolution unit with a built-in branch history table (BHT). It is the parametrised successor to the combinational ID branch comparator, and adds four things:
- signed and zero-relative compare modes;
- operand-ready stalling;
- registered resolution with mispredict detection;
- a 2-bit saturating-counter predictor that the IF stage reads for taken/not-taken prediction.

Parameters:
DATA_W, 32, operand width in bits
PC_W, 32, program counter width in bits
BHT_DEPTH, 64, number of BHT entries; power of two, minimum 2
IDX_LSB, 2, lowest PC bit used for the BHT index (word-aligned instructions)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  branch instruction present in ID
i_con_bop  input  3  branch op from branch_jump decode
i_pc  input  PC_W  PC of the branch in ID
i_pred_taken_id  input  1  prediction made at fetch, carried down with the instruction
i_data_rs  input  DATA_W  rs operand (forwarded value)
i_data_rt  input  DATA_W  rt operand (forwarded value)
i_rs_ready  input  1  rs value is final
i_rt_ready  input  1  rt value is final
i_flush  input  1  kill the ID instruction; no resolve, no BHT update
i_pred_pc  input  PC_W  IF-stage lookup PC
o_pred_taken  output  1  IF prediction, combinational
o_stall  output  1  hold IF/ID, combinational
o_resolve_valid  output  1  one-cycle pulse: resolution is valid
o_con_ifbranch  output  1  resolved taken/not taken
o_mispredict  output  1  resolved outcome differs from i_pred_taken_id

Behaviour:
- Compare encodings (bop):
  - 001 beq: rs==rt
  - 010 bne: rs!=rt
  - 011 blez: signed rs<=0
  - 100 bgtz: signed rs>0
  - 101 bltz: signed rs<0
  - 110 bgez: signed rs>=0
  - 111: unconditional, always taken
  - 000: not a branch; i_valid is ignored and no resolve occurs.
- Zero-relative ops (011–110) take rt from neither input and ignore i_rt_ready; they need rs only.
- ready = i_rs_ready & (i_rt_ready | bop is zero-relative); op 111 is always ready.
- FSM has two states, IDLE and WAIT.
  - IDLE, i_valid & bop!=0 & !i_flush:
    - ready: resolve at this clock edge, stay in IDLE.
    - not ready: o_stall=1, latch bop, pc and pred into holding registers, go to WAIT.
  - WAIT:
    - Compare uses the latched bop/pc/pred and the live i_data_rs/i_data_rt.
    - o_stall = !ready.
    - When ready: resolve at this edge, go to IDLE.
  - i_flush in either state: go to IDLE, no resolve, no BHT write, o_stall=0 that cycle. Flush has priority over ready.
- Resolve at the clock edge (registered outputs, latency 1 cycle from the ready cycle):
  - o_resolve_valid=1 for exactly one cycle;
  - o_con_ifbranch = outcome;
  - o_mispredict = outcome ^ pred.
- When not resolving: o_resolve_valid=0, o_mispredict=0, and o_con_ifbranch holds its last value.
- BHT: BHT_DEPTH x 2-bit counters, indexed by pc[IDX_LSB +: log2(BHT_DEPTH)].
  - On resolve: increment if taken, decrement if not; saturate at 11 and 00.
  - Op 111 also updates the BHT.
- o_pred_taken = MSB of the counter at the i_pred_pc index. It is combinational and reads the pre-update value when a lookup and an update hit the same index in the same cycle.
- Reset (asynchronous): state=IDLE, all BHT counters=01 (weakly not taken), o_resolve_valid=0, o_con_ifbranch=0, o_mispredict=0, holding registers=0. Reset during WAIT abandons the branch with no update.
- Back-to-back branches: one branch can resolve per cycle while IDLE with ready; the BHT updates on consecutive edges are independent.

Test Plan:
- Reset, then resolve beq with rs=rt=0x0000_1234, pred=0 → next cycle o_resolve_valid=1, o_con_ifbranch=1, o_mispredict=1; counter for pc moves 01→10.
- blez with rs=0xFFFF_FFFF and i_rt_ready=0 → no stall; resolves taken (signed −1 ≤ 0); bgtz with the same rs → not taken.
- bne with i_rt_ready low for 3 cycles → o_stall=1 for exactly those 3 cycles, state=WAIT; ready in cycle 4 gives o_stall=0 and the resolve pulse in cycle 5.
- Resolve 4 taken branches at pc=0x40 → o_pred_taken for i_pred_pc=0x40 reads 1 after the first resolve and the counter saturates at 11; then 3 not-taken resolves → counter reaches 00 and o_pred_taken=0.
- Flush in WAIT → o_stall drops that cycle, no resolve pulse, BHT unchanged. Separately, assert i_rst during WAIT → outputs 0 and BHT back at 01 immediately, without waiting for a clock edge.
- Same-cycle resolve and lookup at equal index with counter=01 → o_pred_taken=0 that cycle and 1 the following cycle.

Source files
------------

// File: rtl/id_branch_resolve_predict_if.sv
// id_branch_resolve_predict_if: ID-stage branch bus between decode/forwarding and the resolve/predict unit
interface id_branch_resolve_predict_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              i_valid;
  logic [2:0]        i_con_bop;
  logic [PC_W-1:0]   i_pc;
  logic              i_pred_taken_id;
  logic [DATA_W-1:0] i_data_rs;
  logic [DATA_W-1:0] i_data_rt;
  logic              i_rs_ready;
  logic              i_rt_ready;
  logic              i_flush;
  logic [PC_W-1:0]   i_pred_pc;
  logic              o_pred_taken;
  logic              o_stall;
  logic              o_resolve_valid;
  logic              o_con_ifbranch;
  logic              o_mispredict;
  modport slave (
    input  i_valid, i_con_bop, i_pc, i_pred_taken_id, i_data_rs, i_data_rt,
           i_rs_ready, i_rt_ready, i_flush, i_pred_pc,
    output o_pred_taken, o_stall, o_resolve_valid, o_con_ifbranch, o_mispredict
  );
  modport master (
    output i_valid, i_con_bop, i_pc, i_pred_taken_id, i_data_rs, i_data_rt,
           i_rs_ready, i_rt_ready, i_flush, i_pred_pc,
    input  o_pred_taken, o_stall, o_resolve_valid, o_con_ifbranch, o_mispredict
  );
endinterface

// File: rtl/id_branch_resolve_predict.sv
// id_branch_resolve_predict: ID branch compare with operand-ready stall, registered resolve and 2-bit BHT
module id_branch_resolve_predict #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_LSB   = 2
) (
  input logic i_clk,
  input logic i_rst,
  id_branch_resolve_predict_if.slave bus
);
  localparam int IW = $clog2(BHT_DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t         state_q, state_d;
  logic [2:0]     bop_q, bop_d;
  logic [IW-1:0]  pc_idx_q, pc_idx_d;
  logic           pred_q, pred_d;
  logic           rv_q, rv_d, br_q, br_d, mp_q, mp_d;
  logic [1:0]     bht_q [BHT_DEPTH];
  logic [1:0]     cnt, cnt_d;
  logic [2:0]     bop;
  logic [IW-1:0]  idx;
  logic           pred, zr, ready, taken, live, resolve, stall, wait_st;
  logic signed [DATA_W-1:0] rs_s;
  always_comb begin
    wait_st  = state_q == WAIT;
    bop      = wait_st ? bop_q : bus.i_con_bop;
    idx      = wait_st ? pc_idx_q : bus.i_pc[IDX_LSB +: IW];
    pred     = wait_st ? pred_q : bus.i_pred_taken_id;
    rs_s     = $signed(bus.i_data_rs);
    zr       = bop >= 3'b011 && bop <= 3'b110;
    ready    = (bop == 3'b111) | (bus.i_rs_ready & (bus.i_rt_ready | zr));
    case (bop)
      3'b001:  taken = bus.i_data_rs == bus.i_data_rt;
      3'b010:  taken = bus.i_data_rs != bus.i_data_rt;
      3'b011:  taken = rs_s <= 0;
      3'b100:  taken = rs_s > 0;
      3'b101:  taken = rs_s < 0;
      3'b110:  taken = rs_s >= 0;
      3'b111:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    // WAIT always holds a real branch, so only IDLE needs the valid/op gate
    live     = (wait_st | (bus.i_valid & bus.i_con_bop != 3'b000)) & ~bus.i_flush;
    resolve  = live & ready;
    stall    = live & ~ready;
    state_d  = stall ? WAIT : IDLE;
    bop_d    = (stall & ~wait_st) ? bus.i_con_bop : bop_q;
    pc_idx_d = (stall & ~wait_st) ? bus.i_pc[IDX_LSB +: IW] : pc_idx_q;
    pred_d   = (stall & ~wait_st) ? bus.i_pred_taken_id : pred_q;
    rv_d     = resolve;
    br_d     = resolve ? taken : br_q;
    mp_d     = resolve & (taken ^ pred);
    cnt      = bht_q[idx];
    cnt_d    = taken ? (cnt == 2'b11 ? cnt : cnt + 2'b01) : (cnt == 2'b00 ? cnt : cnt - 2'b01);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      bop_q    <= '0;
      pc_idx_q <= '0;
      pred_q   <= 1'b0;
      rv_q     <= 1'b0;
      br_q     <= 1'b0;
      mp_q     <= 1'b0;
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q  <= state_d;
      bop_q    <= bop_d;
      pc_idx_q <= pc_idx_d;
      pred_q   <= pred_d;
      rv_q     <= rv_d;
      br_q     <= br_d;
      mp_q     <= mp_d;
      if (resolve) bht_q[idx] <= cnt_d;
    end
  end
  assign bus.o_pred_taken    = bht_q[bus.i_pred_pc[IDX_LSB +: IW]][1];
  assign bus.o_stall         = stall;
  assign bus.o_resolve_valid = rv_q;
  assign bus.o_con_ifbranch  = br_q;
  assign bus.o_mispredict    = mp_q;
endmodule

// File: tb/tb_id_branch_resolve_predict.sv
// tb_id_branch_resolve_predict: directed scenarios plus randomized traffic against a pending-branch/counter model
module tb_id_branch_resolve_predict;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  int bht [64];
  id_branch_resolve_predict_if #(.DATA_W(32), .PC_W(32)) bus ();
  id_branch_resolve_predict dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic int ix(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit ref_taken(logic [2:0] bop, logic [31:0] rs, logic [31:0] rt);
    int signed s;
    s = rs;
    case (bop)
      3'd1: return rs == rt;
      3'd2: return rs != rt;
      3'd3: return s <= 0;
      3'd4: return s > 0;
      3'd5: return s < 0;
      3'd6: return s >= 0;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_ready(logic [2:0] bop, bit rsr, bit rtr);
    if (bop == 3'd7) return 1'b1;
    if (bop >= 3'd3 && bop <= 3'd6) return rsr;
    return rsr && rtr;
  endfunction

  function automatic bit ref_pred(logic [31:0] pc);
    return bht[ix(pc)] >= 2;
  endfunction

  task automatic model_resolve(logic [31:0] pc, bit t);
    int k;
    k = ix(pc);
    if (t) bht[k] = (bht[k] == 3) ? 3 : bht[k] + 1;
    else bht[k] = (bht[k] == 0) ? 0 : bht[k] - 1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht[i] = 1;
  endtask

  task automatic set(bit v, logic [2:0] bop, logic [31:0] pc, bit pred, logic [31:0] rs, logic [31:0] rt,
                     bit rsr, bit rtr, bit fl);
    bus.i_valid = v; bus.i_con_bop = bop; bus.i_pc = pc; bus.i_pred_taken_id = pred;
    bus.i_data_rs = rs; bus.i_data_rt = rt; bus.i_rs_ready = rsr; bus.i_rt_ready = rtr; bus.i_flush = fl;
    #1;
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.i_pred_pc = 32'h40;
    idle();
    #10;
    total++; if (bus.o_resolve_valid !== 1'b0) $display("FAIL reset_rv got=%b exp=0", bus.o_resolve_valid); else passed++;
    total++; if (bus.o_con_ifbranch !== 1'b0) $display("FAIL reset_br got=%b exp=0", bus.o_con_ifbranch); else passed++;
    total++; if (bus.o_mispredict !== 1'b0) $display("FAIL reset_mp got=%b exp=0", bus.o_mispredict); else passed++;
    total++; if (bus.o_pred_taken !== 1'b0) $display("FAIL reset_pred got=%b exp=0", bus.o_pred_taken); else passed++;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_beq();
    set(1, 3'd1, 32'h100, 0, 32'h1234, 32'h1234, 1, 1, 0);
    total++; if (bus.o_stall !== 1'b0) $display("FAIL beq_stall got=%b exp=0", bus.o_stall); else passed++;
    tick();
    model_resolve(32'h100, 1);
    idle();
    total++; if (bus.o_resolve_valid !== 1'b1) $display("FAIL beq_rv got=%b exp=1", bus.o_resolve_valid); else passed++;
    total++; if (bus.o_con_ifbranch !== 1'b1) $display("FAIL beq_br got=%b exp=1", bus.o_con_ifbranch); else passed++;
    total++; if (bus.o_mispredict !== 1'b1) $display("FAIL beq_mp got=%b exp=1", bus.o_mispredict); else passed++;
    bus.i_pred_pc = 32'h100; #1;
    total++; if (bus.o_pred_taken !== ref_pred(32'h100)) $display("FAIL beq_pred got=%b exp=%b", bus.o_pred_taken, ref_pred(32'h100)); else passed++;
    tick();
    total++; if (bus.o_resolve_valid !== 1'b0) $display("FAIL beq_rv_drop got=%b exp=0", bus.o_resolve_valid); else passed++;
    total++; if (bus.o_con_ifbranch !== 1'b1) $display("FAIL beq_br_hold got=%b exp=1", bus.o_con_ifbranch); else passed++;
    total++; if (bus.o_mispredict !== 1'b0) $display("FAIL beq_mp_drop got=%b exp=0", bus.o_mispredict); else passed++;
  endtask

  task automatic test_zero_rel();
    set(1, 3'd3, 32'h104, 1, 32'hFFFF_FFFF, 32'h5, 1, 0, 0);
    total++; if (bus.o_stall !== 1'b0) $display("FAIL blez_stall got=%b exp=0", bus.o_stall); else passed++;
    tick();
    model_resolve(32'h104, 1);
    total++; if (bus.o_resolve_valid !== 1'b1) $display("FAIL blez_rv got=%b exp=1", bus.o_resolve_valid); else passed++;
    total++; if (bus.o_con_ifbranch !== 1'b1) $display("FAIL blez_br got=%b exp=1", bus.o_con_ifbranch); else passed++;
    total++; if (bus.o_mispredict !== 1'b0) $display("FAIL blez_mp got=%b exp=0", bus.o_mispredict); else passed++;
    set(1, 3'd4, 32'h108, 1, 32'hFFFF_FFFF, 32'h5, 1, 0, 0);
    tick();
    model_resolve(32'h108, 0);
    idle();
    total++; if (bus.o_resolve_valid !== 1'b1) $display("FAIL bgtz_rv got=%b exp=1", bus.o_resolve_valid); else passed++;
    total++; if (bus.o_con_ifbranch !== 1'b0) $display("FAIL bgtz_br got=%b exp=0", bus.o_con_ifbranch); else passed++;
    total++; if (bus.o_mispredict !== 1'b1) $display("FAIL bgtz_mp got=%b exp=1", bus.o_mispredict); else passed++;
    tick();
  endtask

  task automatic test_stall();
    set(1, 3'd2, 32'h200, 0, 32'h1, 32'h2, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      total++; if (bus.o_stall !== 1'b1) $display("FAIL stall_c%0d got=%b exp=1", c, bus.o_stall); else passed++;
      tick();
      total++; if (bus.o_resolve_valid !== 1'b0) $display("FAIL stall_rv_c%0d got=%b exp=0", c, bus.o_resolve_valid); else passed++;
      set(1, 3'd1, 32'h44, 1, 32'h1, 32'h2, 1, 0, 0);
    end
    set(1, 3'd1, 32'h44, 1, 32'h1, 32'h2, 1, 1, 0);
    total++; if (bus.o_stall !== 1'b0) $display("FAIL stall_release got=%b exp=0", bus.o_stall); else passed++;
    tick();
    model_resolve(32'h200, 1);
    idle();
    total++; if (bus.o_resolve_valid !== 1'b1) $display("FAIL stall_rv got=%b exp=1", bus.o_resolve_valid); else passed++;
    total++; if (bus.o_con_ifbranch !== 1'b1) $display("FAIL stall_br got=%b exp=1", bus.o_con_ifbranch); else passed++;
    total++; if (bus.o_mispredict !== 1'b1) $display("FAIL stall_mp got=%b exp=1", bus.o_mispredict); else passed++;
    bus.i_pred_pc = 32'h200; #1;
    total++; if (bus.o_pred_taken !== ref_pred(32'h200)) $display("FAIL stall_pred got=%b exp=%b", bus.o_pred_taken, ref_pred(32'h200)); else passed++;
    bus.i_pred_pc = 32'h44; #1;
    total++; if (bus.o_pred_taken !== ref_pred(32'h44)) $display("FAIL stall_pred_junk got=%b exp=%b", bus.o_pred_taken, ref_pred(32'h44)); else passed++;
    tick();
  endtask

  task automatic test_saturation();
    bus.i_pred_pc = 32'h40;
    for (int i = 0; i < 7; i++) begin
      bit t;
      t = i < 4;
      set(1, t ? 3'd1 : 3'd2, 32'h40, 0, 32'h9, 32'h9, 1, 1, 0);
      tick();
      model_resolve(32'h40, t);
      idle();
      total++; if (bus.o_pred_taken !== ref_pred(32'h40)) $display("FAIL sat_pred_%0d got=%b exp=%b", i, bus.o_pred_taken, ref_pred(32'h40)); else passed++;
    end
    total++; if (bus.o_pred_taken !== 1'b0) $display("FAIL sat_final got=%b exp=0", bus.o_pred_taken); else passed++;
  endtask

  task automatic test_flush();
    set(1, 3'd7, 32'h80, 0, 0, 0, 0, 0, 0);
    tick();
    model_resolve(32'h80, 1);
    set(1, 3'd2, 32'h80, 1, 32'h3, 32'h3, 1, 0, 0);
    total++; if (bus.o_stall !== 1'b1) $display("FAIL flush_enter got=%b exp=1", bus.o_stall); else passed++;
    tick();
    set(1, 3'd2, 32'h80, 1, 32'h3, 32'h3, 1, 1, 1);
    total++; if (bus.o_stall !== 1'b0) $display("FAIL flush_stall got=%b exp=0", bus.o_stall); else passed++;
    tick();
    idle();
    total++; if (bus.o_resolve_valid !== 1'b0) $display("FAIL flush_rv got=%b exp=0", bus.o_resolve_valid); else passed++;
    bus.i_pred_pc = 32'h80; #1;
    total++; if (bus.o_pred_taken !== ref_pred(32'h80)) $display("FAIL flush_bht got=%b exp=%b", bus.o_pred_taken, ref_pred(32'h80)); else passed++;
    set(1, 3'd2, 32'h80, 0, 32'h3, 32'h3, 1, 1, 1);
    total++; if (bus.o_stall !== 1'b0) $display("FAIL flush_idle_stall got=%b exp=0", bus.o_stall); else passed++;
    tick();
    idle();
    total++; if (bus.o_resolve_valid !== 1'b0) $display("FAIL flush_idle_rv got=%b exp=0", bus.o_resolve_valid); else passed++;
    total++; if (bus.o_pred_taken !== ref_pred(32'h80)) $display("FAIL flush_idle_bht got=%b exp=%b", bus.o_pred_taken, ref_pred(32'h80)); else passed++;
  endtask

  task automatic test_reset_wait();
    set(1, 3'd7, 32'h80, 0, 0, 0, 0, 0, 0);
    tick();
    model_resolve(32'h80, 1);
    set(1, 3'd1, 32'h80, 0, 32'h1, 32'h1, 0, 1, 0);
    tick();
    total++; if (bus.o_con_ifbranch !== 1'b1) $display("FAIL rstw_pre_br got=%b exp=1", bus.o_con_ifbranch); else passed++;
    bus.i_pred_pc = 32'h80; #1;
    total++; if (bus.o_pred_taken !== 1'b1) $display("FAIL rstw_pre_pred got=%b exp=1", bus.o_pred_taken); else passed++;
    bus.i_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (bus.o_con_ifbranch !== 1'b0) $display("FAIL rstw_br got=%b exp=0", bus.o_con_ifbranch); else passed++;
    total++; if (bus.o_resolve_valid !== 1'b0) $display("FAIL rstw_rv got=%b exp=0", bus.o_resolve_valid); else passed++;
    total++; if (bus.o_stall !== 1'b0) $display("FAIL rstw_stall got=%b exp=0", bus.o_stall); else passed++;
    total++; if (bus.o_pred_taken !== 1'b0) $display("FAIL rstw_pred got=%b exp=0", bus.o_pred_taken); else passed++;
    tick();
    rst = 1'b0;
    idle();
    tick();
    total++; if (bus.o_resolve_valid !== 1'b0) $display("FAIL rstw_after_rv got=%b exp=0", bus.o_resolve_valid); else passed++;
  endtask

  task automatic test_same_cycle();
    bus.i_pred_pc = 32'h1C;
    set(1, 3'd1, 32'h1C, 0, 32'h7, 32'h7, 1, 1, 0);
    total++; if (bus.o_pred_taken !== ref_pred(32'h1C)) $display("FAIL same_pre got=%b exp=%b", bus.o_pred_taken, ref_pred(32'h1C)); else passed++;
    tick();
    model_resolve(32'h1C, 1);
    idle();
    total++; if (bus.o_pred_taken !== 1'b1) $display("FAIL same_post got=%b exp=1", bus.o_pred_taken); else passed++;
    total++; if (bus.o_pred_taken !== ref_pred(32'h1C)) $display("FAIL same_model got=%b exp=%b", bus.o_pred_taken, ref_pred(32'h1C)); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h55};
    bit pend = 0;
    logic [2:0] pbop = 0;
    logic [31:0] ppc = 0;
    bit ppred = 0;
    bit last_br = bus.o_con_ifbranch;
    for (int n = 0; n < 400; n++) begin
      bit v, pr, rsr, rtr, fl, act, rdy, t, xp, es, res;
      logic [2:0] bop, eb;
      logic [31:0] pc, rs, rt, epc;
      v = $urandom_range(0, 3) != 0;
      bop = 3'($urandom_range(0, 7));
      pc = {$urandom_range(0, 3), 4'b0, 2'($urandom_range(0, 3)), 2'b00} ;
      pr = 1'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? $urandom : vals[$urandom_range(0, 5)];
      rt = ($urandom_range(0, 1) == 0) ? rs : vals[$urandom_range(0, 5)];
      rsr = $urandom_range(0, 3) != 0;
      rtr = $urandom_range(0, 3) != 0;
      fl = $urandom_range(0, 9) == 0;
      bus.i_pred_pc = {$urandom_range(0, 3), 4'b0, 2'($urandom_range(0, 3)), 2'b00};
      set(v, bop, pc, pr, rs, rt, rsr, rtr, fl);
      eb = pend ? pbop : bop;
      epc = pend ? ppc : pc;
      xp = pend ? ppred : pr;
      act = (pend || (v && bop != 0)) && !fl;
      rdy = ref_ready(eb, rsr, rtr);
      t = ref_taken(eb, rs, rt);
      es = act && !rdy;
      res = act && rdy;
      total++; if (bus.o_stall !== es) $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, bus.o_stall, es); else passed++;
      total++; if (bus.o_pred_taken !== ref_pred(bus.i_pred_pc)) $display("FAIL rnd_pred n=%0d got=%b exp=%b", n, bus.o_pred_taken, ref_pred(bus.i_pred_pc)); else passed++;
      tick();
      if (res) begin
        model_resolve(epc, t);
        last_br = t;
      end
      if (es && !pend) begin
        pbop = bop; ppc = pc; ppred = pr;
      end
      pend = es;
      total++; if (bus.o_resolve_valid !== res) $display("FAIL rnd_rv n=%0d got=%b exp=%b", n, bus.o_resolve_valid, res); else passed++;
      total++; if (bus.o_con_ifbranch !== last_br) $display("FAIL rnd_br n=%0d got=%b exp=%b", n, bus.o_con_ifbranch, last_br); else passed++;
      total++; if (bus.o_mispredict !== (res && (t ^ xp))) $display("FAIL rnd_mp n=%0d got=%b exp=%b", n, bus.o_mispredict, res && (t ^ xp)); else passed++;
    end
    idle();
  endtask

  initial begin
    bus.i_pred_pc = 0;
    test_reset();
    test_beq();
    test_zero_rel();
    test_stall();
    test_saturation();
    test_flush();
    test_same_cycle();
    test_reset_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
